// File: rtl/conv3x3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_pkg
//  Description : Shared constants for the 3x3 stream convolver: operator
//                mode encodings, Gaussian kernel weights, rounding constants
//                and the internal sum-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package conv3x3_pkg;

    // Operator selection; code 3 is reserved and behaves as identity.
    localparam logic [1:0] MODE_GAUSS = 2'd0;
    localparam logic [1:0] MODE_SOBEL = 2'd1;
    localparam logic [1:0] MODE_IDENT = 2'd2;

    // 1 2 1 / 2 4 2 / 1 2 1 Gaussian kernel, normalised by 16 with round-half-up.
    localparam int unsigned GAUSS_CORNER = 1;
    localparam int unsigned GAUSS_EDGE   = 2;
    localparam int unsigned GAUSS_CENTRE = 4;
    localparam int unsigned GAUSS_ROUND  = 8;
    localparam int unsigned GAUSS_SHIFT  = 4;

    // Wide enough for the full Gaussian sum (16 * max) and |Gx|+|Gy| (8 * max).
    function automatic int sum_width(input int pix_w);
        return pix_w + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_chan.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_chan
//  Description : Single-channel 3-stage 3x3 operator datapath.
//                S1: weighted row / column partial sums.
//                S2: Gaussian sum and |Gx|+|Gy|.
//                S3: mode select, rounding, saturation -> pix.
//  Ports       : clk, rst_n (sync, active-low), en (pipeline advance),
//                mode (operator of the beat entering S1), win (9 taps,
//                tap t = row*3+col at [t*PIX_W +: PIX_W]), pix (S3 result).
//  Revision    : 1.0  initial release
// ============================================================================
module conv3x3_chan
    import conv3x3_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [9*PIX_W-1:0]   win,
    output logic [PIX_W-1:0]     pix
);

    localparam int SW = sum_width(PIX_W);
    localparam int RW = PIX_W + 3;               // holds the 8x-weighted centre row
    localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};

    function automatic logic [RW-1:0] weigh(input logic [PIX_W-1:0] v, input int unsigned w);
        return RW'(v) * RW'(w);
    endfunction

    logic [PIX_W-1:0] p [9];

    always_comb begin
        for (int t = 0; t < 9; t++) begin
            p[t] = win[t*PIX_W +: PIX_W];
        end
    end

    // Stage registers
    logic [RW-1:0]    row0_q, row0_d, row1_q, row1_d, row2_q, row2_d;
    logic [RW-1:0]    col_l_q, col_l_d, col_r_q, col_r_d;
    logic [PIX_W-1:0] ctr1_q, ctr1_d, ctr2_q, ctr2_d;
    logic [1:0]       mode1_q, mode1_d, mode2_q, mode2_d;
    logic [SW-1:0]    gsum_q, gsum_d, ssum_q, ssum_d;
    logic [PIX_W-1:0] pix_q, pix_d;

    // Combinational intermediates
    logic [SW-1:0]    w_gx, w_gy, w_abs_x, w_abs_y, w_round;
    logic [PIX_W-1:0] w_gauss_pix, w_sobel_pix;
    logic             w_unused_round;

    always_comb begin
        // S2 arithmetic on S1 registers; subtraction is two's complement in SW bits.
        w_gx    = SW'(col_r_q) - SW'(col_l_q);
        w_gy    = SW'(row2_q)  - SW'(row0_q);
        w_abs_x = w_gx[SW-1] ? (~w_gx + SW'(1)) : w_gx;
        w_abs_y = w_gy[SW-1] ? (~w_gy + SW'(1)) : w_gy;

        // S3 arithmetic on S2 registers
        w_round        = gsum_q + SW'(GAUSS_ROUND);
        w_gauss_pix    = w_round[GAUSS_SHIFT +: PIX_W];
        w_unused_round = ^w_round[GAUSS_SHIFT-1:0];
        w_sobel_pix    = (ssum_q > SW'(PIX_MAX)) ? PIX_MAX : ssum_q[PIX_W-1:0];

        row0_d  = row0_q;
        row1_d  = row1_q;
        row2_d  = row2_q;
        col_l_d = col_l_q;
        col_r_d = col_r_q;
        ctr1_d  = ctr1_q;
        mode1_d = mode1_q;
        gsum_d  = gsum_q;
        ssum_d  = ssum_q;
        ctr2_d  = ctr2_q;
        mode2_d = mode2_q;
        pix_d   = pix_q;

        if (en) begin
            // S1: Gaussian rows double as the Sobel top/bottom rows for Gy.
            row0_d  = weigh(p[0], GAUSS_CORNER) + weigh(p[1], GAUSS_EDGE)   + weigh(p[2], GAUSS_CORNER);
            row1_d  = weigh(p[3], GAUSS_EDGE)   + weigh(p[4], GAUSS_CENTRE) + weigh(p[5], GAUSS_EDGE);
            row2_d  = weigh(p[6], GAUSS_CORNER) + weigh(p[7], GAUSS_EDGE)   + weigh(p[8], GAUSS_CORNER);
            col_l_d = RW'(p[0]) + (RW'(p[3]) << 1) + RW'(p[6]);
            col_r_d = RW'(p[2]) + (RW'(p[5]) << 1) + RW'(p[8]);
            ctr1_d  = p[4];
            mode1_d = mode;

            // S2
            gsum_d  = SW'(row0_q) + SW'(row1_q) + SW'(row2_q);
            ssum_d  = w_abs_x + w_abs_y;
            ctr2_d  = ctr1_q;
            mode2_d = mode1_q;

            // S3
            case (mode2_q)
                MODE_GAUSS: pix_d = w_gauss_pix;
                MODE_SOBEL: pix_d = w_sobel_pix;
                MODE_IDENT: pix_d = ctr2_q;
                default:    pix_d = ctr2_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row0_q  <= '0;
            row1_q  <= '0;
            row2_q  <= '0;
            col_l_q <= '0;
            col_r_q <= '0;
            ctr1_q  <= '0;
            mode1_q <= '0;
            gsum_q  <= '0;
            ssum_q  <= '0;
            ctr2_q  <= '0;
            mode2_q <= '0;
            pix_q   <= '0;
        end else begin
            row0_q  <= row0_d;
            row1_q  <= row1_d;
            row2_q  <= row2_d;
            col_l_q <= col_l_d;
            col_r_q <= col_r_d;
            ctr1_q  <= ctr1_d;
            mode1_q <= mode1_d;
            gsum_q  <= gsum_d;
            ssum_q  <= ssum_d;
            ctr2_q  <= ctr2_d;
            mode2_q <= mode2_d;
            pix_q   <= pix_d;
        end
    end

    assign pix = pix_q;

endmodule
`default_nettype wire

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_stream
//  Description : NCH-channel 3x3 operator (Gaussian / Sobel magnitude /
//                identity) with valid/ready on both sides. 3-stage pipeline,
//                one global enable, 1 beat/cycle throughput.
//  Ports       : clk, rst_n (sync, active-low)
//                in_valid/in_ready/in_mode/in_last/win_i : input beat
//                out_valid/out_ready/pix_o/out_last       : output beat
//  Revision    : 1.0  initial release
// ============================================================================
module conv3x3_stream
    import conv3x3_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int NCH   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_mode,
    input  logic                     in_last,
    input  logic [NCH*9*PIX_W-1:0]   win_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NCH*PIX_W-1:0]     pix_o,
    output logic                     out_last
);

    logic en;
    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    logic s1_last_q,  s1_last_d,  s2_last_q,  s2_last_d,  s3_last_q,  s3_last_d;

    // The whole pipe moves together; it only stalls when the output slot is
    // occupied and not being taken. Bubbles are kept, not squeezed out.
    always_comb begin
        en         = !s3_valid_q || out_ready;
        in_ready   = en;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s3_valid_d = s3_valid_q;
        s1_last_d  = s1_last_q;
        s2_last_d  = s2_last_q;
        s3_last_d  = s3_last_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_last_d  = in_last;
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s3_valid_d = s2_valid_q;
            s3_last_d  = s2_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            s3_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            s1_last_q  <= s1_last_d;
            s2_last_q  <= s2_last_d;
            s3_last_q  <= s3_last_d;
        end
    end

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            conv3x3_chan #(
                .PIX_W (PIX_W)
            ) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .mode  (in_mode),
                .win   (win_i[c*9*PIX_W +: 9*PIX_W]),
                .pix   (pix_o[c*PIX_W +: PIX_W])
            );
        end
    endgenerate

    assign out_valid = s3_valid_q;
    assign out_last  = s3_last_q;

endmodule
`default_nettype wire

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Parametrised successor to the fixed RGB Gaussian convolver.
- Applies a selectable 3x3 operator (Gaussian, Sobel magnitude, identity) to NCH channels in parallel, each of PIX_W bits.
- Fully pipelined with valid/ready handshakes on both sides.
- Sits between the line-buffer/window generator and the pixel packer; replaces the start-strobe interface with proper backpressure.

Parameters:
- PIX_W, 8, bits per channel sample, for both input taps and output.
- NCH, 3, number of channels processed in parallel.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  window beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_mode  in  2  operator for this beat: 0 Gaussian, 1 Sobel, 2 identity, 3 reserved (treated as identity).
- in_last  in  1  end-of-line sideband; passes through with the beat.
- win_i  in  NCH*9*PIX_W  taps. Channel c, tap t = row*3+col, is at bits [(c*9+t)*PIX_W +: PIX_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- pix_o  out  NCH*PIX_W  results. Channel c is at [c*PIX_W +: PIX_W]; channel 0 occupies the LSBs.
- out_last  out  1  in_last of the beat now on the output.

Behaviour:
- Reset is sampled on the clk edge while rst_n=0:
  - all stage valids clear, so out_valid=0;
  - pix_o=0 and out_last=0;
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation drops every in-flight beat; none is emitted afterwards.
- Pipeline has 3 stages: S1, S2, S3. S3 drives the outputs.
- A single enable en = !s3_valid || out_ready advances all stages; in_ready = en.
- A beat is accepted on in_valid && in_ready.
- Latency: an accepted beat appears on out_valid exactly 3 cycles later if out_ready was held 1.
- Bubbles are not collapsed. With out_ready=0 the pipe holds at most 3 beats.
- While out_valid && !out_ready: pix_o, out_last and out_valid stay stable.
- Simultaneous output drain and input accept in one cycle is legal. Full throughput is 1 beat/cycle.
- Mode and last travel with their beat. Changing in_mode between beats needs no flush.
- Per channel, all taps are unsigned (p00..p22):
  - Gaussian:
    - sum = 1,2,1 / 2,4,2 / 1,2,1 weighted sum, width PIX_W+4;
    - result = (sum + 8) >> 4, round-half-up;
    - no overflow possible, so no saturation is needed.
  - Sobel:
    - Gx = (p02+2p12+p22) - (p00+2p10+p20);
    - Gy = (p20+2p21+p22) - (p00+2p01+p02);
    - both signed, width PIX_W+4;
    - result = min(|Gx|+|Gy|, 2^PIX_W-1).
  - Identity: result = p11.
- Stage split:
  - S1 registers the weighted row/column partial sums;
  - S2 forms Gauss sum, Gx, Gy and the absolute values;
  - S3 applies mode selection, rounding and saturation into the output register.
- All intermediates are sized to avoid wrap; no truncation occurs before the final round/saturate.
- in_valid=0 during accept cycles inserts a bubble. win_i is ignored when not accepted.

Decomposition:
- Package conv3x3_pkg holds:
  - mode constants MODE_GAUSS=0, MODE_SOBEL=1, MODE_IDENT=2;
  - the Gaussian kernel weights and round constant (8) / shift (4);
  - a function returning the internal sum width from PIX_W.
- Sub-module conv3x3_chan: single-channel 3-stage datapath. It takes mode and enable and is instantiated NCH times by generate.
- Handshake, valid/last pipeline and the enable live in the top module.

Test Plan (PIX_W=8, NCH=3):
- Gaussian flat: all taps 100, mode 0, out_ready=1 -> pix_o channels all 100, out_valid 3 cycles after accept.
- Gaussian impulse and rounding:
  - centre 255, others 0, mode 0 -> 64 ((1020+8)>>4) on every channel;
  - centre 2, others 0 -> 1.
- Sobel:
  - left column 0, right column 255 -> Gx=1020, saturates to 255;
  - right column 10, left column 0 -> 40;
  - flat 77 -> 0.
- Per-channel independence and mode switching:
  - back-to-back beats with modes 0,1,2 and distinct R/G/B values -> per-beat correct results in order, one per cycle;
  - out_last follows its beat.
- Backpressure:
  - out_ready=0 with in_valid held -> exactly 3 beats accepted, then in_ready=0 and outputs stable;
  - release out_ready -> beats drain in order with no loss or duplication.
- Reset mid-stream: rst_n=0 for one edge with 2 beats in flight -> out_valid=0, pix_o=0 next cycle, in_ready=1, no stale beat emitted later.
